// File: rtl/bit_deser8.sv
// Serial-to-parallel capture stage: assembles LSB-first bits into WIDTH-bit words
// and queues them in a small valid/ready FIFO with a sticky overflow flag.
module bit_deser8 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             sof,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-2:0] shreg, shreg_n;
    logic             push;
    logic [WIDTH-1:0] word;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, pop, wr_en, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
        end
    end

    // A sof always restarts the word, even mid-word in SHIFT, so no push happens then.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        push    = 1'b0;
        word    = {bit_in, shreg};
        case (state)
            IDLE: begin
                if (bit_vld && sof) begin
                    state_n    = SHIFT;
                    shreg_n    = '0;
                    shreg_n[0] = bit_in;
                    cnt_n      = CW'(1);
                end
            end
            SHIFT: begin
                if (bit_vld) begin
                    if (sof) begin
                        shreg_n    = '0;
                        shreg_n[0] = bit_in;
                        cnt_n      = CW'(1);
                    end else if (cnt == LAST_BIT) begin
                        push  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        shreg_n[cnt] = bit_in;
                        cnt_n        = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    // Entries are cleared on reset so out_data reads as zero until the first word lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_deser8.sv
// Testbench for bit_deser8: scenario tasks drive serial words and a negedge
// scoreboard compares every popped word against the expected-word queue.
module tb_bit_deser8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in;
    logic       bit_vld;
    logic       sof;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       clr_ovf;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;

    bit_deser8 #(.WIDTH(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .sof       (sof),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // Every accepted head word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL pop_unexpected: got %h, required no word", out_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (out_data !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL pop_data: got %h, required %h", out_data, exp_word);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic s);
        bit_in  = b;
        bit_vld = 1'b1;
        sof     = s;
        tick();
        bit_vld = 1'b0;
        sof     = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic with_sof, input logic gaps,
                             input logic exp_out, input logic ready_last);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) tick();
            if (i == 7 && ready_last) out_ready = 1'b1;
            drive_bit(w[i], with_sof && (i == 0));
            if (i == 7 && exp_out) exp_q.push_back(w);
        end
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_missing: got %0d words pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({out_valid, overflow, out_data} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b o=%b d=%h, required 0/0/00", out_valid, overflow, out_data);
        end
        rst_n   = 1'b1;
        bit_vld = 1'b1;
        sof     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_in = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({out_valid, overflow, out_data} !== 10'b0) begin
                errors++;
                $display("[TB] FAIL idle_ignore: got v=%b o=%b d=%h, required 0/0/00", out_valid, overflow, out_data);
            end
        end
        bit_vld = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_word(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL basic_latency: got v=%b d=%h, required 1/a5", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_one_cycle: got v=%b, required 0", out_valid);
        end
        drain(2);
    endtask

    task automatic test_gapped_resync();
        out_ready = 1'b1;
        send_word(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
        send_word(8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
        drain(4);
    endtask

    task automatic test_backpressure();
        logic [7:0] w3;
        w3 = 8'h33;
        out_ready = 1'b0;
        send_word(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("[TB] FAIL bp_first: got v=%b d=%h, required 1/11", out_valid, out_data);
        end
        send_word(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold: got v=%b d=%h o=%b, required 1/11/0", out_valid, out_data, overflow);
        end
        for (int i = 0; i < 7; i++) drive_bit(w3[i], 1'b0);
        clr_ovf = 1'b1;
        drive_bit(w3[7], 1'b0);
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("[TB] FAIL bp_drop_set_wins: got o=%b v=%b d=%h, required 1/1/11", overflow, out_valid, out_data);
        end
        drain(4);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_sticky: got o=%b, required 1", overflow);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_clear: got o=%b, required 0", overflow);
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        send_word(8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h55) begin
            errors++;
            $display("[TB] FAIL full_pop: got o=%b v=%b d=%h, required 0/1/55", overflow, out_valid, out_data);
        end
        drain(4);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_word(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL mid_queued: got v=%b d=%h, required 1/5a", out_valid, out_data);
        end
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        bit_in  = 1'b1;
        bit_vld = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_async_reset: got v=%b o=%b d=%h, required 0/0/00", out_valid, overflow, out_data);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bit_vld = 1'b0;
        out_ready = 1'b1;
        send_word(8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hF0) begin
            errors++;
            $display("[TB] FAIL mid_after_reset: got v=%b d=%h, required 1/f0", out_valid, out_data);
        end
        drain(3);
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_vld   = 1'b0;
        sof       = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        test_reset();
        test_basic();
        test_gapped_resync();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: got no completion, required finish before 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
